uart_rx_oversample: RTL
=======================

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit period; even, >= 4.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sampleTick  input  1  one-clk pulse at OVERSAMPLE x baud rate, from the baud generator.
REQ-006 SHALL have port rxIn  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rxReady  input  1  consumer ready.
REQ-008 SHALL have port rxData  output  DATA_BITS  received word, stable while rxValid high.
REQ-009 SHALL have port rxValid  output  1  word available.
REQ-010 SHALL have port frameErr  output  1  one-clk pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-clk pulse when a good frame is dropped.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rxIn through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rxS.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH; tick counter and bit counter advance only on cycles with sampleTick=1.
REQ-015 IDLE: on sampleTick with rxS=0 -> START, tick counter cleared.
REQ-016 START: on the (OVERSAMPLE/2)th tick after entry, rxS=0 -> DATA (counters cleared); rxS=1 -> IDLE, glitch, no flags raised.
REQ-017 DATA: every OVERSAMPLE ticks, sample rxS into the shift register LSB-first (shift right, insert at MSB); after DATA_BITS samples -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks, sample rxS; 1 = good frame -> IDLE; 0 -> frameErr pulse, word discarded, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until a sampleTick with rxS=1, then -> IDLE; no start detection while in WAIT_HIGH.
REQ-020 Good frame with rxValid=0: rxData loaded and rxValid set on the clock edge after the stop-sample tick (1-clk latency).
REQ-021 rxValid SHALL clear on the edge after a cycle where rxValid and rxReady are both 1; rxData unchanged while rxValid=1.
REQ-022 Good frame completing while rxValid=1 and rxReady=0: new word dropped, rxData retained, overrun pulses for 1 clk.
REQ-023 Good frame completing in the same cycle as a handshake: new word loaded, rxValid stays 1, no overrun.
REQ-024 sampleTick ignored in no state except as stated; with sampleTick held 0 the FSM SHALL hold.
REQ-025 Counters SHALL be $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1) bits wide, wrapping only through explicit clear.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counters 0, shift register 0, synchronizer 1, rxData 0, rxValid 0, frameErr 0, overrun 0, busy 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no flags on release; reception resumes at the next start bit after release.

Structure
REQ-028 A shared package uart_pkg SHALL hold the rx state enum and the default DATA_BITS/OVERSAMPLE constants.
REQ-029 The synchronizer SHALL be a separate sub-module sync2 (2 flops, reset value parameterized); all other logic stays in uart_rx_oversample.

Verification (DATA_BITS=8, OVERSAMPLE=16, sampleTick every 4 clk)
REQ-030 Frame 0x55 (start, 1010_1010 LSB-first, stop), rxReady=1 -> rxData=0x55, rxValid one clk, no flags.
REQ-031 rxIn low for 6 ticks then high -> returns to IDLE, rxValid, frameErr, overrun all stay 0.
REQ-032 Frame 0xA3 with stop bit 0, line held low 40 ticks -> frameErr one pulse, no rxValid, no restart until line high; next 0x3C received correctly.
REQ-033 rxReady=0, frames 0x11 then 0x22 -> rxData=0x11 held, overrun one pulse at end of 0x22; then rxReady=1 -> 0x11 accepted.
REQ-034 rxReady pulsed in the exact completion cycle of 0x77 while 0x66 pending -> rxData=0x77, rxValid stays 1, overrun 0.
REQ-035 rst_n low during bit 4 of 0xF0 -> all outputs 0 asynchronously; after release, frame 0x0F received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: default frame geometry and the rx FSM state encoding.
package uart_pkg;

  localparam int unsigned DEF_DATA_BITS  = 8;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset value is a parameter.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: mid-bit sampling off an external tick, ready/valid output
// with single-clock frameErr / overrun pulses.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sampleTick,
  input  logic                 rxIn,
  input  logic                 rxReady,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  output logic                 frameErr,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 done;
  logic                 rx_s;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxIn),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      done     <= 1'b0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
      done     <= 1'b0;

      // A completed word lands one clock after its stop sample; a same-cycle handshake frees the slot.
      if (done) begin
        if (!rxValid || rxReady) begin
          rxData  <= shreg;
          rxValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end

      if (sampleTick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              state    <= ST_START;
              busy     <= 1'b1;
              tick_cnt <= '0;
            end
          end
          ST_START: begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_s) begin
                state <= ST_DATA;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == BIT_LAST) begin
                state <= ST_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= ST_WAIT_HIGH;
                frameErr <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          ST_WAIT_HIGH: begin
            // A broken frame must see the line return high before hunting for a new start bit.
            if (rx_s) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
